// File: rtl/frog_collision.sv
// Frog-vs-car collision detector and lives/game-state FSM.
// Collisions are sampled on frame_tick while playing; a hit freezes play for HIT_FRAMES frames.
module frog_collision #(
  parameter int CAR_WIDTH  = 32,
  parameter int CAR_HEIGHT = 32,
  parameter int FROG_SIZE  = 32,
  parameter int LIVES_INIT = 3,
  parameter int HIT_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [9:0]  frog_x,
  input  logic [9:0]  frog_y,
  input  logic [39:0] car_x_bus,
  input  logic [39:0] car_y_bus,
  output logic        hit,
  output logic        frog_respawn,
  output logic [2:0]  lives,
  output logic        game_over,
  output logic        freeze
);

  typedef enum logic [1:0] {PLAYING, HIT, GAME_OVER} state_t;

  localparam int CW = (HIT_FRAMES < 2) ? 1 : $clog2(HIT_FRAMES + 1);

  state_t          state, state_nx;
  logic [2:0]      lives_r, lives_nx;
  logic [CW-1:0]   cnt, cnt_nx, cnt_inc;
  logic            hit_r, hit_nx;
  logic            resp_r, resp_nx;
  logic [3:0]      ovl;
  logic [10:0]     fx, fy;

  // Widen to 11 bits so position + size never wraps near the 1023 edge.
  assign fx = {1'b0, frog_x};
  assign fy = {1'b0, frog_y};

  for (genvar i = 0; i < 4; i++) begin : g_car
    logic [10:0] cx, cy;
    assign cx = {1'b0, car_x_bus[10*i +: 10]};
    assign cy = {1'b0, car_y_bus[10*i +: 10]};
    assign ovl[i] = (fx < cx + 11'(CAR_WIDTH))  && (cx < fx + 11'(FROG_SIZE)) &&
                    (fy < cy + 11'(CAR_HEIGHT)) && (cy < fy + 11'(FROG_SIZE));
  end

  assign cnt_inc = cnt + CW'(1);

  always_comb begin
    state_nx = state;
    lives_nx = lives_r;
    cnt_nx   = cnt;
    hit_nx   = 1'b0;
    resp_nx  = 1'b0;
    case (state)
      PLAYING: begin
        if (frame_tick && (|ovl) && (lives_r != 3'd0)) begin
          hit_nx   = 1'b1;
          lives_nx = lives_r - 3'd1;
          cnt_nx   = '0;
          state_nx = (lives_r == 3'd1) ? GAME_OVER : HIT;
        end
      end
      HIT: begin
        if (frame_tick) begin
          if (cnt_inc == CW'(HIT_FRAMES)) begin
            state_nx = PLAYING;
            resp_nx  = 1'b1;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
      end
      GAME_OVER: begin
        if (start) begin
          state_nx = PLAYING;
          lives_nx = 3'(LIVES_INIT);
          resp_nx  = 1'b1;
        end
      end
      default: state_nx = PLAYING;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= PLAYING;
      lives_r <= 3'(LIVES_INIT);
      cnt     <= '0;
      hit_r   <= 1'b0;
      resp_r  <= 1'b0;
    end else begin
      state   <= state_nx;
      lives_r <= lives_nx;
      cnt     <= cnt_nx;
      hit_r   <= hit_nx;
      resp_r  <= resp_nx;
    end
  end

  assign hit          = hit_r;
  assign frog_respawn = resp_r;
  assign lives        = lives_r;
  assign freeze       = (state == HIT);
  assign game_over    = (state == GAME_OVER);

endmodule
